// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - HI/LO unit opcode and FSM state types
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_MF    = 3'd7
    } hilo_op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } hilo_state_t;

endpackage

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register owner sequencing Mult/Div requests and MFHI/MFLO/MTHI/MTLO
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             stall,
    output logic [WIDTH-1:0] read_hi,
    output logic [WIDTH-1:0] read_lo,
    output logic             mul_valid_in,
    output logic             mul_sign,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic             mul_valid_out,
    input  logic [WIDTH-1:0] mul_hi,
    input  logic [WIDTH-1:0] mul_lo,
    output logic             div_valid_in,
    output logic             div_sign,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_valid_out,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo
);

    hilo_state_t      state;
    hilo_state_t      state_next;
    hilo_op_t         op_e;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             start_mul;
    logic             start_div;
    logic             write_hi;
    logic             write_lo;
    logic             mul_done;
    logic             div_done;

    assign op_e    = hilo_op_t'(op);
    assign stall   = (state != IDLE);
    assign read_hi = hi;
    assign read_lo = lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Completion pulses are honoured only from the unit currently requested.
    always_comb begin
        state_next = state;
        start_mul  = 1'b0;
        start_div  = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        mul_done   = 1'b0;
        div_done   = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    case (op_e)
                        OP_MULT, OP_MULTU: begin
                            start_mul  = 1'b1;
                            state_next = MUL_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            start_div  = 1'b1;
                            state_next = DIV_BUSY;
                        end
                        OP_MTHI: write_hi = 1'b1;
                        OP_MTLO: write_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MUL_BUSY: begin
                if (mul_valid_out) begin
                    mul_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            DIV_BUSY: begin
                if (div_valid_out) begin
                    div_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (mul_done) begin
            hi <= mul_hi;
            lo <= mul_lo;
        end else if (div_done) begin
            hi <= div_hi;
            lo <= div_lo;
        end else begin
            if (write_hi) hi <= src_a;
            if (write_lo) lo <= src_a;
        end
    end

    // Operands and sign stay frozen until the next start; the units re-read them at completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_valid_in <= 1'b0;
            mul_sign     <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
        end else if (start_mul) begin
            mul_valid_in <= 1'b1;
            mul_sign     <= (op_e == OP_MULT);
            mul_a        <= src_a;
            mul_b        <= src_b;
        end else if (mul_done) begin
            mul_valid_in <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_valid_in <= 1'b0;
            div_sign     <= 1'b0;
            div_a        <= '0;
            div_b        <= '0;
        end else if (start_div) begin
            div_valid_in <= 1'b1;
            div_sign     <= (op_e == OP_DIV);
            div_a        <= src_a;
            div_b        <= src_b;
        end else if (div_done) begin
            div_valid_in <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed self-checking bench for hilo_unit with fixed-latency Mult/Div models
module tb_hilo_unit;
    import hilo_pkg::*;

    localparam int W       = 32;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         op_valid = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         stall;
    logic [W-1:0] read_hi, read_lo;
    logic         mul_valid_in, mul_sign, mul_valid_out;
    logic [W-1:0] mul_a, mul_b, mul_hi, mul_lo;
    logic         div_valid_in, div_sign, div_valid_out;
    logic [W-1:0] div_a, div_b, div_hi, div_lo;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hilo_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .stall(stall),
        .read_hi(read_hi), .read_lo(read_lo),
        .mul_valid_in(mul_valid_in), .mul_sign(mul_sign), .mul_a(mul_a), .mul_b(mul_b),
        .mul_valid_out(mul_valid_out), .mul_hi(mul_hi), .mul_lo(mul_lo),
        .div_valid_in(div_valid_in), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
        .div_valid_out(div_valid_out), .div_hi(div_hi), .div_lo(div_lo)
    );

    function automatic logic [63:0] mul_product(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] p;
        if (s) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        else   p = {32'b0, a} * {32'b0, b};
        return p;
    endfunction

    function automatic logic [63:0] div_result(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [31:0] q, r;
        if (b == 32'd0) return '1;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    // Unit models: count while valid_in is high, pulse once, clear when valid_in drops.
    logic         mdl_mul_vo = 1'b0, mul_fin = 1'b0;
    logic [W-1:0] mdl_mul_hi = '0, mdl_mul_lo = '0;
    int           mul_cnt = 0;
    logic         mdl_div_vo = 1'b0, div_fin = 1'b0;
    logic [W-1:0] mdl_div_hi = '0, mdl_div_lo = '0;
    int           div_cnt = 0;
    logic         inj_mul = 1'b0, inj_div = 1'b0;
    logic [W-1:0] inj_val = 32'hDEAD_BEEF;

    always @(posedge clk) begin
        mdl_mul_vo <= 1'b0;
        if (!mul_valid_in) begin
            mul_cnt <= 0;
            mul_fin <= 1'b0;
        end else if (!mul_fin) begin
            if (mul_cnt == MUL_LAT - 1) begin
                mdl_mul_vo <= 1'b1;
                mul_fin    <= 1'b1;
                {mdl_mul_hi, mdl_mul_lo} <= mul_product(mul_a, mul_b, mul_sign);
            end else begin
                mul_cnt <= mul_cnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        mdl_div_vo <= 1'b0;
        if (!div_valid_in) begin
            div_cnt <= 0;
            div_fin <= 1'b0;
        end else if (!div_fin) begin
            if (div_cnt == DIV_LAT - 1) begin
                mdl_div_vo <= 1'b1;
                div_fin    <= 1'b1;
                {mdl_div_hi, mdl_div_lo} <= div_result(div_a, div_b, div_sign);
            end else begin
                div_cnt <= div_cnt + 1;
            end
        end
    end

    assign mul_valid_out = mdl_mul_vo | inj_mul;
    assign mul_hi        = inj_mul ? inj_val : mdl_mul_hi;
    assign mul_lo        = inj_mul ? inj_val : mdl_mul_lo;
    assign div_valid_out = mdl_div_vo | inj_div;
    assign div_hi        = inj_div ? inj_val : mdl_div_hi;
    assign div_lo        = inj_div ? inj_val : mdl_div_lo;

    int mul_pulses = 0;
    int stall_cycles = 0;
    always @(negedge clk) begin
        if (mul_valid_out) mul_pulses++;
        if (stall) stall_cycles++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        step();
        op_valid = 1'b0;
        op       = OP_NONE;
    endtask

    // Waits out a busy period, counting stalled cycles and operand/sign changes.
    task automatic wait_busy(input logic is_div, input logic [W-1:0] ea, input logic [W-1:0] eb,
                             input logic es, output int n, output int bad);
        n   = 0;
        bad = 0;
        while (stall && n < 50) begin
            if (is_div) begin
                if (div_a !== ea || div_b !== eb || div_sign !== es || div_valid_in !== 1'b1) bad++;
            end else begin
                if (mul_a !== ea || mul_b !== eb || mul_sign !== es || mul_valid_in !== 1'b1) bad++;
            end
            n++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, p0, s0;

        repeat (3) step();
        reset = 1'b0;
        check("rst_stall", stall, 0);
        check("rst_hi", read_hi, 0);
        check("rst_lo", read_lo, 0);
        check("rst_mul_vin", mul_valid_in, 0);
        check("rst_div_vin", div_valid_in, 0);
        check("rst_mul_sign", mul_sign, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_div_b", div_b, 0);

        // MULT -3 * 7
        p0 = mul_pulses;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult_vin", mul_valid_in, 1);
        check("mult_stall", stall, 1);
        wait_busy(1'b0, 32'hFFFF_FFFD, 32'd7, 1'b1, n, bad);
        check("mult_stall_cycles", n, MUL_LAT + 1);
        check("mult_held", bad, 0);
        check("mult_hi", read_hi, 64'hFFFF_FFFF);
        check("mult_lo", read_lo, 64'hFFFF_FFEB);
        check("mult_vin_drop", mul_valid_in, 0);
        check("mult_pulses", mul_pulses - p0, 1);

        // MULTU 0xFFFFFFFF * 2
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        check("multu_sign", mul_sign, 0);
        wait_busy(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, n, bad);
        check("multu_held", bad, 0);
        check("multu_hi", read_hi, 1);
        check("multu_lo", read_lo, 64'hFFFF_FFFE);

        // Back-to-back MULT 5*6 then MULT 7*8 re-presented while busy
        p0 = mul_pulses;
        op_valid = 1'b1; op = OP_MULT; src_a = 32'd5; src_b = 32'd6;
        step();
        src_a = 32'd7; src_b = 32'd8;
        wait_busy(1'b0, 32'd5, 32'd6, 1'b1, n, bad);
        check("b2b_first_held", bad, 0);
        check("b2b_gap_vin", mul_valid_in, 0);
        check("b2b_mid_lo", read_lo, 30);
        step();
        op_valid = 1'b0; op = OP_NONE;
        check("b2b_second_a", mul_a, 7);
        wait_busy(1'b0, 32'd7, 32'd8, 1'b1, n, bad);
        check("b2b_second_held", bad, 0);
        check("b2b_hi", read_hi, 0);
        check("b2b_lo", read_lo, 56);
        step();
        check("b2b_pulses", mul_pulses - p0, 2);

        // MTHI / MTLO / MF without stall
        s0 = stall_cycles;
        issue(OP_MTHI, 32'h1234, 32'hFFFF);
        check("mthi_hi", read_hi, 64'h1234);
        issue(OP_MTLO, 32'h5678, 32'hFFFF);
        check("mtlo_lo", read_lo, 64'h5678);
        check("mtlo_hi_kept", read_hi, 64'h1234);
        op_valid = 1'b1; op = OP_MF;
        check("mf_hi", read_hi, 64'h1234);
        check("mf_lo", read_lo, 64'h5678);
        step();
        op_valid = 1'b0; op = OP_NONE;
        step();
        check("mt_mf_no_stall", stall_cycles - s0, 0);

        // DIV 100/7 with MFLO presented while busy
        p0 = mul_pulses;
        op_valid = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
        step();
        op = OP_MF;
        wait_busy(1'b1, 32'd100, 32'd7, 1'b1, n, bad);
        check("div_stall_cycles", n, DIV_LAT + 1);
        check("div_held", bad, 0);
        check("div_lo", read_lo, 14);
        check("div_hi", read_hi, 2);
        check("div_mul_idle", mul_valid_in, 0);
        step();
        op_valid = 1'b0; op = OP_NONE;
        check("div_mf_no_stall", stall, 0);
        check("div_vin_drop", div_valid_in, 0);
        check("div_no_mul_pulse", mul_pulses - p0, 0);

        // Stray div pulse in IDLE is ignored
        inj_div = 1'b1;
        step();
        inj_div = 1'b0;
        step();
        check("stray_div_hi", read_hi, 2);
        check("stray_div_lo", read_lo, 14);

        // op_valid with NONE
        issue(OP_NONE, 32'hAAAA_AAAA, 32'h5555_5555);
        check("none_stall", stall, 0);
        check("none_hi", read_hi, 2);

        // Reset two cycles into a MULT, then a late completion pulse
        issue(OP_MULT, 32'd9, 32'd9);
        step();
        step();
        check("rstmid_busy", stall, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstmid_stall", stall, 0);
        check("rstmid_hi", read_hi, 0);
        check("rstmid_lo", read_lo, 0);
        check("rstmid_vin", mul_valid_in, 0);
        inj_mul = 1'b1;
        step();
        inj_mul = 1'b0;
        step();
        check("late_pulse_hi", read_hi, 0);
        check("late_pulse_lo", read_lo, 0);
        check("late_pulse_stall", stall, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
